// File: rtl/data_ram_pipe_pkg.sv
// Shared constants and types for the pipelined byte-lane data RAM.
// Word geometry, legal read latencies and the pipeline stage record.
package data_ram_pipe_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_LANES = WORD_W / BYTE_W;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  // One response slot travelling down the pipe; data rides alongside it.
  typedef struct packed {
    logic valid;
    logic err;
    logic is_write;
  } stage_t;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One 8-bit lane of the data RAM: synchronous write, registered read.
// The read register only loads when re is high, so it holds through stalls.
module data_ram_lane
  import data_ram_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [BYTE_W-1:0] mem [DEPTH];

  // NOTE: storage and its read register have no reset; contents must survive
  // resetn, and the pipeline valid bits decide whether rdata is ever seen.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram_pipe.sv
// Pipelined single-port data RAM with byte-lane writes, in-order responses,
// out-of-range error reporting and full-pipeline backpressure.
module data_ram_pipe
  import data_ram_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = WORD_W,
  parameter int unsigned DEPTH_LOG2 = 17,
  parameter int unsigned RD_LAT     = 1,
  parameter bit          WR_RSP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W/8-1:0]   req_sel,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned LANES = lane_count(DATA_W);

  logic                  stall;
  logic                  accept;
  logic                  addr_err;
  logic                  rd_en;
  logic                  takes_slot;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_W-1:0]     ram_rdata;
  stage_t                s0_q;
  stage_t                last_st;
  logic [DATA_W-1:0]     last_word;

  // The whole pipe freezes while the head response waits; reset also closes the door.
  assign stall      = rsp_valid & ~rsp_ready;
  assign req_ready  = resetn & ~stall;
  assign accept     = req_valid & req_ready;
  assign word_idx   = req_addr[DEPTH_LOG2+1:2];
  assign addr_err   = |(req_addr >> (DEPTH_LOG2 + 2));
  assign rd_en      = accept & ~req_we & ~addr_err;
  assign takes_slot = ~req_we | addr_err | WR_RSP;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_ram_lane #(
      .ADDR_W (DEPTH_LOG2)
    ) u_lane (
      .clk   (clk),
      .we    (accept & req_we & ~addr_err & req_sel[i]),
      .re    (rd_en),
      .addr  (word_idx),
      .wdata (req_wdata[BYTE_W*i +: BYTE_W]),
      .rdata (ram_rdata[BYTE_W*i +: BYTE_W])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_q <= '0;
    end else if (!stall) begin
      s0_q.valid    <= accept & takes_slot;
      s0_q.err      <= addr_err;
      s0_q.is_write <= req_we;
    end
  end

  if (RD_LAT == 1) begin : g_no_chain
    assign last_st   = s0_q;
    assign last_word = ram_rdata;
  end else begin : g_chain
    for (genvar k = 1; k < RD_LAT; k++) begin : g_stage
      stage_t            st_d;
      stage_t            st_q;
      logic [DATA_W-1:0] word_d;
      logic [DATA_W-1:0] word_q;

      if (k == 1) begin : g_head
        assign st_d   = s0_q;
        assign word_d = ram_rdata;
      end else begin : g_link
        assign st_d   = g_stage[k-1].st_q;
        assign word_d = g_stage[k-1].word_q;
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          st_q   <= '0;
          word_q <= '0;
        end else if (!stall) begin
          st_q   <= st_d;
          word_q <= word_d;
        end
      end
    end

    assign last_st   = g_stage[RD_LAT-1].st_q;
    assign last_word = g_stage[RD_LAT-1].word_q;
  end

  // Only good reads expose RAM data; writes, errors and idle cycles show zero.
  assign rsp_valid = last_st.valid;
  assign rsp_err   = last_st.valid & last_st.err;
  assign rsp_rdata = (last_st.valid & ~last_st.err & ~last_st.is_write) ? last_word : '0;

endmodule
